bias_load_sequencer: RTL and testbench

//  Controller for the bias-addition datapath. On start it clears the bias unit and fetches
//  num_channels biases from memory, with up to MAX_OUTSTANDING reads in flight. It streams

---
 rtl/bias_load_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_bias_load_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_load_sequencer.sv
// Bias-load controller: clears the bias unit, fetches N biases with bounded reads in flight,
// streams them into the bias load port, then enables the datapath and tracks channel_idx.
module bias_load_sequencer #(
    parameter int unsigned BIAS_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_CHANNELS    = 512,
    parameter int unsigned MAX_OUTSTANDING = 4,
    // num_channels carries one bit more than channel_idx so MAX_CHANNELS itself is expressible
    localparam int unsigned CNT_W = $clog2(MAX_CHANNELS + 1),
    localparam int unsigned IDX_W = $clog2(MAX_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]      num_channels,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [BIAS_WIDTH-1:0] mem_rdata,
    output logic                  load_bias,
    output logic                  bias_valid,
    output logic [BIAS_WIDTH-1:0] bias_in,
    input  logic                  bias_loaded,
    output logic                  enable,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    output logic                  acc_fire,
    output logic [IDX_W-1:0]      channel_idx
);

    localparam int unsigned STRIDE = BIAS_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT_LOADED,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [CNT_W-1:0]      issue_q, issue_d;
    logic [CNT_W-1:0]      resp_q, resp_d;
    logic [CNT_W-1:0]      ch_q, ch_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;
    logic                  bvalid_q, bvalid_d;
    logic [BIAS_WIDTH-1:0] bias_q, bias_d;

    logic                  start_legal;
    logic [CNT_W-1:0]      in_flight;
    logic                  req;
    logic                  grant;
    logic                  rsp_ok;
    logic                  rsp_bad;
    logic                  fire;

    assign start_legal = (num_channels != '0) && (num_channels <= CNT_W'(MAX_CHANNELS));
    assign in_flight   = issue_q - resp_q;
    // req can only fall on a grant, so mem_req/mem_addr stay stable while waiting for mem_gnt
    assign req         = (state_q == S_FETCH) && (issue_q < n_q)
                         && (in_flight < CNT_W'(MAX_OUTSTANDING));
    assign grant       = req && mem_gnt;
    assign rsp_ok      = (state_q == S_FETCH) && mem_rvalid && (resp_q != issue_q);
    assign rsp_bad     = mem_rvalid && !rsp_ok;
    assign fire        = (state_q == S_RUN) && acc_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            n_q      <= '0;
            issue_q  <= '0;
            resp_q   <= '0;
            ch_q     <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            bvalid_q <= 1'b0;
            bias_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            issue_q  <= issue_d;
            resp_q   <= resp_d;
            ch_q     <= ch_d;
            error_q  <= error_d;
            done_q   <= done_d;
            bvalid_q <= bvalid_d;
            bias_q   <= bias_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        issue_d  = issue_q;
        resp_d   = resp_q;
        ch_d     = ch_q;
        error_d  = error_q;
        done_d   = 1'b0;
        bvalid_d = 1'b0;
        bias_d   = bias_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        state_d = S_CLEAR;
                        base_d  = base_addr;
                        n_d     = num_channels;
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                issue_d = '0;
                resp_d  = '0;
                ch_d    = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (grant) begin
                    issue_d = issue_q + CNT_W'(1);
                end
                if (rsp_ok) begin
                    resp_d   = resp_q + CNT_W'(1);
                    bvalid_d = 1'b1;
                    bias_d   = mem_rdata;
                    if (resp_q + CNT_W'(1) == n_q) begin
                        state_d = S_WAIT_LOADED;
                    end
                end
            end
            S_WAIT_LOADED: begin
                if (bias_loaded) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (fire) begin
                    ch_d = (ch_q == n_q - CNT_W'(1)) ? '0 : ch_q + CNT_W'(1);
                end
                // A legal start outranks stop and reloads; an illegal one only flags error
                if (start && start_legal) begin
                    state_d = S_CLEAR;
                    base_d  = base_addr;
                    n_d     = num_channels;
                    error_d = 1'b0;
                end else begin
                    if (start) begin
                        error_d = 1'b1;
                    end
                    if (stop) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rsp_bad) begin
            error_d = 1'b1;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign mem_req     = req;
    assign mem_addr    = req ? (base_q + ADDR_WIDTH'(issue_q) * ADDR_WIDTH'(STRIDE)) : '0;
    assign load_bias   = (state_q == S_CLEAR);
    assign bias_valid  = bvalid_q;
    assign bias_in     = bias_q;
    assign enable      = (state_q == S_RUN);
    assign acc_ready   = (state_q == S_RUN);
    assign acc_fire    = fire;
    assign channel_idx = ch_q[IDX_W-1:0];

endmodule

// File: tb/tb_bias_load_sequencer.sv
// Scoreboard bench for bias_load_sequencer: a memory responder and stimulus push expectations,
// a negedge monitor pops and compares whenever the DUT presents a grant, strobe or beat.
module tb_bias_load_sequencer;

    localparam int unsigned AW   = 32;
    localparam int unsigned BW   = 32;
    localparam int unsigned MAXC = 512;
    localparam int unsigned MAXO = 4;
    localparam int          BIG  = 1000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [AW-1:0] base_addr;
    logic [9:0]    num_channels;
    logic          busy;
    logic          done;
    logic          error;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [BW-1:0] mem_rdata;
    logic          load_bias;
    logic          bias_valid;
    logic [BW-1:0] bias_in;
    logic          bias_loaded;
    logic          enable;
    logic          acc_valid;
    logic          acc_ready;
    logic          acc_fire;
    logic [8:0]    channel_idx;

    always #5 clk = ~clk;

    bias_load_sequencer #(
        .BIAS_WIDTH     (BW),
        .ADDR_WIDTH     (AW),
        .MAX_CHANNELS   (MAXC),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .base_addr   (base_addr),
        .num_channels(num_channels),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .load_bias   (load_bias),
        .bias_valid  (bias_valid),
        .bias_in     (bias_in),
        .bias_loaded (bias_loaded),
        .enable      (enable),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_fire    (acc_fire),
        .channel_idx (channel_idx)
    );

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] exp_addr[$];
    logic [BW-1:0] exp_bias[$];
    int            exp_ch[$];
    int            pend[$];

    int cyc = 0;
    int bv_cnt = 0, load_cnt = 0, load_bv = 0, done_cnt = 0, grant_cnt = 0;
    int lat_min = 1, lat_max = 2;
    bit gnt_rand = 1'b0;
    bit discard = 1'b0;
    int resp_limit = BIG;
    int resp_given = 0;
    int layer_bv0, layer_done0, layer_load0;
    int ch_k;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory model: in-order responses a random number of cycles after each grant
    initial begin : responder
        int tmp;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (pend.size() > 0 && pend[0] <= cyc && resp_given < resp_limit) begin
                tmp        = pend.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                resp_given++;
                if (!discard) exp_bias.push_back(mem_rdata);
            end
            mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (mem_req && mem_gnt) pend.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        end
    end

    initial begin : monitor
        bit            req_wait;
        logic [AW-1:0] held_addr;
        req_wait  = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_wait = 1'b0;
            end else begin
                if (req_wait)
                    check("req_hold", 64'({mem_req, mem_addr}), 64'({1'b1, held_addr}));
                req_wait  = mem_req && !mem_gnt;
                held_addr = mem_addr;
                if (mem_req && mem_gnt) begin
                    grant_cnt++;
                    check("addr_expected", 64'(exp_addr.size() != 0), 64'(1));
                    if (exp_addr.size() != 0) check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
                end
                if (load_bias) begin
                    load_cnt++;
                    load_bv = bv_cnt;
                end
                if (bias_valid) begin
                    bv_cnt++;
                    check("bias_expected", 64'(exp_bias.size() != 0), 64'(1));
                    if (exp_bias.size() != 0) check("bias_in", 64'(bias_in), 64'(exp_bias.pop_front()));
                end
                if (acc_fire) begin
                    check("beat_expected", 64'(exp_ch.size() != 0), 64'(1));
                    if (exp_ch.size() != 0) check("channel_idx", 64'(channel_idx), 64'(exp_ch.pop_front()));
                end
                if (done) begin
                    done_cnt++;
                    check("done_in_run", 64'(enable), 64'(1));
                end
            end
        end
    end

    task automatic begin_layer(input logic [AW-1:0] base, input int n, input bit with_stop);
        logic [AW-1:0] a;
        layer_bv0   = bv_cnt;
        layer_done0 = done_cnt;
        layer_load0 = load_cnt;
        ch_k        = 0;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i) * AW'(BW / 8);
            exp_addr.push_back(a);
        end
        base_addr    = base;
        num_channels = 10'(n);
        start        = 1'b1;
        stop         = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("load_bias_pulse", 64'(load_bias), 64'(1));
        check("busy_after_start", 64'(busy), 64'(1));
        check("start_clears_error", 64'(error), 64'(0));
    endtask

    task automatic finish_layer(input int n, input int beats, input bit all_valid, input bit poke);
        int t;
        t = 0;
        while (bv_cnt < layer_bv0 + n && t < 20 * n + 100) begin
            if (poke && t == 3) begin
                start        = 1'b1;
                num_channels = 10'(n + 1);
                base_addr    = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            t++;
        end
        start = 1'b0;
        check("strobe_count", 64'(bv_cnt - layer_bv0), 64'(n));
        check("load_before_strobes", 64'(load_bv), 64'(layer_bv0));
        check("load_once", 64'(load_cnt - layer_load0), 64'(1));
        check("addr_drained", 64'(exp_addr.size()), 64'(0));
        check("bias_drained", 64'(exp_bias.size()), 64'(0));
        repeat ($urandom_range(0, 3)) tick();
        check("no_early_done", 64'(done_cnt - layer_done0), 64'(0));
        check("wait_not_enabled", 64'(enable), 64'(0));
        bias_loaded = 1'b1;
        t = 0;
        while (done_cnt == layer_done0 && t < 20) begin
            tick();
            t++;
        end
        bias_loaded = 1'b0;
        check("run_enable", 64'(enable), 64'(1));
        for (int j = 0; j < beats; j++) begin
            acc_valid = all_valid || ($urandom_range(0, 2) != 0);
            if (acc_valid) begin
                exp_ch.push_back(ch_k % n);
                ch_k++;
            end
            tick();
        end
        acc_valid = 1'b0;
        tick();
        check("done_once", 64'(done_cnt - layer_done0), 64'(1));
        check("ch_drained", 64'(exp_ch.size()), 64'(0));
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop      = 1'b0;
        acc_valid = 1'b1;
        @(negedge clk);
        check("stop_enable", 64'(enable), 64'(0));
        check("stop_busy", 64'(busy), 64'(0));
        check("stop_acc_ready", 64'(acc_ready), 64'(0));
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic bad_start(input int n);
        num_channels = 10'(n);
        start        = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("bad_start_error", 64'(error), 64'(1));
        check("bad_start_idle", 64'(busy), 64'(0));
        tick();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int g0;
        int t;
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        base_addr    = '0;
        num_channels = '0;
        bias_loaded  = 1'b0;
        acc_valid    = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_load_bias", 64'(load_bias), 64'(0));
        check("rst_bias_valid", 64'(bias_valid), 64'(0));
        check("rst_enable", 64'(enable), 64'(0));
        check("rst_acc_fire", 64'(acc_fire), 64'(0));
        check("rst_channel_idx", 64'(channel_idx), 64'(0));
        tick();
        rst       = 1'b0;
        acc_valid = 1'b0;
        tick();

        // T1: four biases from 0x100, fixed two-cycle latency
        lat_min = 2; lat_max = 2; gnt_rand = 1'b0;
        begin_layer(32'h100, 4, 1'b0);
        finish_layer(4, 4, 1'b1, 1'b0);
        stop_run();

        // T2: responses withheld, request window caps at MAX_OUTSTANDING
        g0         = grant_cnt;
        resp_limit = resp_given;
        begin_layer(32'h2000, 8, 1'b0);
        repeat (12) tick();
        check("t2_grants_capped", 64'(grant_cnt - g0), 64'(MAXO));
        @(negedge clk);
        check("t2_req_low", 64'(mem_req), 64'(0));
        resp_limit = resp_given + 1;
        t = 0;
        while (grant_cnt - g0 < int'(MAXO) + 1 && t < 10) begin
            tick();
            t++;
        end
        check("t2_req_after_rvalid", 64'(grant_cnt - g0), 64'(MAXO + 1));
        resp_limit = BIG;
        finish_layer(8, 5, 1'b0, 1'b0);
        stop_run();

        // T3 then T5: channel wrap, then start+stop in RUN reloads
        begin_layer($urandom, 3, 1'b0);
        finish_layer(3, 7, 1'b1, 1'b0);
        begin_layer($urandom, 5, 1'b1);
        finish_layer(5, 6, 1'b0, 1'b0);
        stop_run();

        // T4: illegal counts, then legal starts clear error; 512 with address wrap
        bad_start(0);
        begin_layer(32'h40, 2, 1'b0);
        finish_layer(2, 3, 1'b0, 1'b0);
        stop_run();
        bad_start(513);
        lat_min = 1; lat_max = 2;
        begin_layer(32'hFFFF_FF00, 512, 1'b0);
        finish_layer(512, 600, 1'b0, 1'b0);
        stop_run();

        // T6: reset mid-fetch after two of four responses; late responses are stray
        lat_min = 2; lat_max = 2;
        resp_limit = resp_given + 2;
        begin_layer(32'h4000, 4, 1'b0);
        t = 0;
        while (bv_cnt - layer_bv0 < 2 && t < 40) begin
            tick();
            t++;
        end
        check("t6_two_strobes", 64'(bv_cnt - layer_bv0), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle", 64'(busy), 64'(0));
        check("t6_req_low", 64'(mem_req), 64'(0));
        exp_addr.delete();
        discard    = 1'b1;
        resp_limit = BIG;
        t = 0;
        while (pend.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        tick();
        tick();
        @(negedge clk);
        check("t6_stray_error", 64'(error), 64'(1));
        discard = 1'b0;
        tick();

        // Random layers with random grant/latency, chained reloads and ignored starts
        gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 20));
            begin_layer($urandom, n, 1'(r % 2));
            finish_layer(n, int'($urandom_range(0, 3 * n)), 1'b0, 1'(r % 2));
            if (r % 3 == 2) stop_run();
        end
        stop_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
